// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the nonce scheduler state encoding.
package sha256_pkg;

  localparam int NONCE_W = 8;

  // Padding words for the two fixed-length blocks of a Bitcoin header hash.
  localparam logic [31:0] PAD_ONE = 32'h8000_0000;
  localparam logic [31:0] LEN_640 = 32'h0000_0280;  // 80-byte header
  localparam logic [31:0] LEN_256 = 32'h0000_0100;  // 32-byte digest

  // SHA-256 initial hash value, word 0 in the top 32 bits.
  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_WAIT_A,
    S_LOAD_B,
    S_WAIT_B,
    S_EMIT,
    S_FINISH
  } sched_state_t;

  // Word idx of the IV.
  function automatic logic [31:0] iv_word(input logic [2:0] idx);
    logic [255:0] v;
    v = SHA256_IV << {idx, 5'd0};
    return v[255:224];
  endfunction

endpackage

// File: rtl/sha256_msg_pad.sv
// Builds the padded message block and initial hash for either pass of the
// double SHA-256; drives all zeros when disabled.
module sha256_msg_pad
  import sha256_pkg::*;
(
  input  logic        i_enable,
  input  logic        i_pass_b,
  input  logic [31:0] i_tail     [0:2],
  input  logic [31:0] i_nonce,
  input  logic [31:0] i_midstate [0:7],
  input  logic [31:0] i_digest   [0:7],
  output logic [31:0] o_message    [0:15],
  output logic [31:0] o_input_hash [0:7]
);

  // Select block layout and initial hash for the active pass.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    for (int i = 0; i < 16; i++) o_message[i] = '0;
    for (int i = 0; i < 8; i++) o_input_hash[i] = '0;
    if (i_enable) begin
      if (!i_pass_b) begin
        for (int i = 0; i < 3; i++) o_message[i] = i_tail[i];
        o_message[3]  = i_nonce;
        o_message[4]  = PAD_ONE;
        o_message[15] = LEN_640;
        for (int i = 0; i < 8; i++) o_input_hash[i] = i_midstate[i];
      end else begin
        for (int i = 0; i < 8; i++) o_message[i] = i_digest[i];
        o_message[8]  = PAD_ONE;
        o_message[15] = LEN_256;
        for (int i = 0; i < 8; i++) o_input_hash[i] = iv_word(3'(i));
      end
    end
  end

endmodule

// File: rtl/bitcoin_nonce_scheduler.sv
// Sequences double-SHA-256 header hashes over a range of nonces using one
// shared external SHA-256 core, emitting one result per nonce.
module bitcoin_nonce_scheduler
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        midstate [0:7],
  input  logic [31:0]        tail [0:2],
  input  logic [NONCE_W-1:0] num_nonces,
  output logic               busy,
  output logic               done,
  output logic               core_start,
  output logic [31:0]        core_input_hash [0:7],
  output logic [31:0]        core_message [0:15],
  input  logic               core_done,
  input  logic [31:0]        core_output_hash [0:7],
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_nonce,
  output logic [31:0]        res_hash [0:7]
);

  sched_state_t       r_state;
  sched_state_t       w_next;
  logic               r_armed;  // second or later cycle of a WAIT state
  logic [31:0]        r_midstate [0:7];
  logic [31:0]        r_tail [0:2];
  logic [NONCE_W-1:0] r_num;
  logic [NONCE_W-1:0] r_n;
  logic [31:0]        r_digest [0:7];
  logic [31:0]        r_res_nonce;
  logic [31:0]        r_res_hash [0:7];

  logic w_accept_job, w_cap_a, w_cap_b, w_accept, w_last, w_pad_en, w_pass_b;
  logic [31:0] w_nonce;

  assign w_accept_job = (r_state == S_IDLE) && start;
  // The core needs a cycle to drop core_done after core_start, so the first
  // WAIT cycle is never trusted.
  assign w_cap_a  = (r_state == S_WAIT_A) && r_armed && core_done;
  assign w_cap_b  = (r_state == S_WAIT_B) && r_armed && core_done;
  assign w_accept = (r_state == S_EMIT) && res_ready;
  assign w_last   = (r_n == r_num - 1'b1);
  assign w_nonce  = {{(32 - NONCE_W){1'b0}}, r_n};
  assign w_pad_en = (r_state == S_LOAD_A) || (r_state == S_WAIT_A) ||
                    (r_state == S_LOAD_B) || (r_state == S_WAIT_B);
  assign w_pass_b = (r_state == S_LOAD_B) || (r_state == S_WAIT_B);

  // State register and WAIT first-cycle tracker.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= (r_state == S_WAIT_A) || (r_state == S_WAIT_B);
    end
  end

  // Next-state decode and core start pulse; LOAD holds until the core is idle.
  always_comb begin
    w_next     = r_state;
    core_start = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = (num_nonces == '0) ? S_FINISH : S_LOAD_A;
      S_LOAD_A: if (core_done) begin
                  core_start = 1'b1;
                  w_next     = S_WAIT_A;
                end
      S_WAIT_A: if (w_cap_a) w_next = S_LOAD_B;
      S_LOAD_B: if (core_done) begin
                  core_start = 1'b1;
                  w_next     = S_WAIT_B;
                end
      S_WAIT_B: if (w_cap_b) w_next = S_EMIT;
      S_EMIT:   if (w_accept) w_next = w_last ? S_FINISH : S_LOAD_A;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Job parameters and pass-A digest; only read in states that follow a load.
  always_ff @(posedge clk) begin
    // NOTE: these wide holding registers carry no reset; nothing consumes them
    // before they are written by an accepted job or a pass-A capture.
    if (w_accept_job) begin
      r_midstate <= midstate;
      r_tail     <= tail;
      r_num      <= num_nonces;
    end
    if (w_cap_a) r_digest <= core_output_hash;
  end

  // Nonce counter and the result holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n         <= '0;
      r_res_nonce <= '0;
      r_res_hash  <= '{default: '0};
    end else begin
      if (w_accept_job) r_n <= '0;
      else if (w_accept && !w_last) r_n <= r_n + 1'b1;
      if (w_cap_b) begin
        r_res_hash  <= core_output_hash;
        r_res_nonce <= w_nonce;
      end
    end
  end

  sha256_msg_pad u_pad (
    .i_enable     (w_pad_en),
    .i_pass_b     (w_pass_b),
    .i_tail       (r_tail),
    .i_nonce      (w_nonce),
    .i_midstate   (r_midstate),
    .i_digest     (r_digest),
    .o_message    (core_message),
    .o_input_hash (core_input_hash)
  );

  assign busy      = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done      = (r_state == S_FINISH);
  assign res_valid = (r_state == S_EMIT);
  assign res_nonce = r_res_nonce;
  assign res_hash  = r_res_hash;

endmodule
